// File: rtl/present_decrypt_iter.sv
// present_decrypt_iter: iterative PRESENT-80 decryption engine.
// Expands the user key forward to the round-32 key, whitens, then runs 31
// inverse rounds (inverse P-layer, inverse S-box layer, round-key XOR).
// Optional key-schedule cache: define PRESENT_DEC_KEYCACHE_EN to enable it.
module present_decrypt_iter #(
  parameter int BLOCK_W = 64,
  parameter int KEY_W   = 80,
  parameter int ROUNDS  = 31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] ciphertext,
  input  logic [KEY_W-1:0]   key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] plaintext,
  output logic               busy
);

  localparam logic [4:0]  RC_LAST      = 5'(ROUNDS);
  // Nibble i of each table holds S(i) / invS(i).
  localparam logic [63:0] SBOX_TBL     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] INV_SBOX_TBL = 64'hA970364BD21C8FE5;

  typedef enum logic [2:0] {IDLE, KEYEXP, WHITEN, DEC, DONE} state_t;

  state_t             state;
  logic [4:0]         rc;
  logic [KEY_W-1:0]   kr;
  logic [BLOCK_W-1:0] st;
  logic [KEY_W-1:0]   kr_enc;
  logic [KEY_W-1:0]   kr_dec;
  logic [BLOCK_W-1:0] st_dec;

`ifdef PRESENT_DEC_KEYCACHE_EN
  logic               cache_vld;
  logic [KEY_W-1:0]   last_key;
  logic [KEY_W-1:0]   last_k32;
  logic               cache_hit;
  assign cache_hit = cache_vld && (key == last_key);
`endif

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return INV_SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] inv_s_layer(input logic [63:0] s);
    logic [63:0] o;
    for (int n = 0; n < 16; n++) o[4*n +: 4] = inv_sbox(s[4*n +: 4]);
    return o;
  endfunction

  // The forward P-layer sends bit i to 16*i mod 63 (bit 63 fixed); pull it back.
  function automatic logic [63:0] inv_p(input logic [63:0] s);
    logic [63:0] o;
    for (int j = 0; j < 63; j++) o[j] = s[(16 * j) % 63];
    o[63] = s[63];
    return o;
  endfunction

  // Forward key-schedule step for round counter r.
  function automatic logic [79:0] ks(input logic [79:0] k, input logic [4:0] r);
    logic [79:0] t;
    t          = {k[18:0], k[79:19]};
    t[79:76]   = sbox(t[79:76]);
    t[19:15]   = t[19:15] ^ r;
    return t;
  endfunction

  // Exact inverse of ks(): undo the counter XOR, the S-box, then the rotation.
  function automatic logic [79:0] iks(input logic [79:0] k, input logic [4:0] r);
    logic [79:0] t;
    t          = k;
    t[19:15]   = t[19:15] ^ r;
    t[79:76]   = inv_sbox(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

  assign kr_enc = ks(kr, rc);
  assign kr_dec = iks(kr, rc);
  assign st_dec = inv_s_layer(inv_p(st)) ^ kr_dec[79:16];

  // Control FSM plus datapath registers; every output is registered.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      plaintext <= '0;
      rc        <= '0;
      kr        <= '0;
      st        <= '0;
`ifdef PRESENT_DEC_KEYCACHE_EN
      cache_vld <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            st       <= ciphertext;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef PRESENT_DEC_KEYCACHE_EN
            if (cache_hit) begin
              kr    <= last_k32;
              rc    <= RC_LAST;
              state <= WHITEN;
            end else begin
              kr        <= key;
              rc        <= 5'd1;
              cache_vld <= 1'b0;
              state     <= KEYEXP;
            end
`else
            kr    <= key;
            rc    <= 5'd1;
            state <= KEYEXP;
`endif
          end
        end
        KEYEXP: begin
          kr <= kr_enc;
          if (rc == RC_LAST) begin
            state <= WHITEN;
`ifdef PRESENT_DEC_KEYCACHE_EN
            cache_vld <= 1'b1;
`endif
          end else begin
            rc <= rc + 5'd1;
          end
        end
        WHITEN: begin
          st    <= st ^ kr[79:16];
          rc    <= RC_LAST;
          state <= DEC;
        end
        DEC: begin
          kr <= kr_dec;
          st <= st_dec;
          rc <= rc - 5'd1;
          if (rc == 5'd1) begin
            plaintext <= st_dec;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PRESENT_DEC_KEYCACHE_EN
  // Cache payload; only meaningful while cache_vld is set.
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; cache_vld alone qualifies them.
    if (state == IDLE && in_valid && in_ready && !cache_hit) last_key <= key;
    if (state == KEYEXP && rc == RC_LAST) last_k32 <= kr_enc;
  end
`endif

endmodule

// File: tb/tb_present_decrypt_iter.sv
// tb_present_decrypt_iter: self-checking bench for present_decrypt_iter.
// Reference model is a plain PRESENT-80 encryptor; random plaintexts are
// encrypted by the model and the DUT must recover them.
module tb_present_decrypt_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ciphertext;
  logic [79:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] plaintext;
  logic        busy;

  int          n_vec = 0;
  int          n_bad = 0;

  // Model of the optional key cache (only consulted when it is compiled in).
  bit          cache_v;
  logic [79:0] last_k;

  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  present_decrypt_iter dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Straight PRESENT-80 encryption: 31 x (key add, S-box, P-layer), final key add.
  function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [79:0] k_in);
    logic [79:0] k;
    logic [63:0] s;
    logic [63:0] t;
    k = k_in;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = SBOX[s[4*n +: 4]];
      for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (16 * i) % 63] = s[i];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = SBOX[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  function automatic int exp_latency(input logic [79:0] k);
    int lat_hit;
`ifdef PRESENT_DEC_KEYCACHE_EN
    lat_hit = 32;
`else
    lat_hit = 63;
`endif
    return (cache_v && k == last_k) ? lat_hit : 63;
  endfunction

  // One block: offer, wait for out_valid (bounded), optionally stall, then hand off.
  task automatic run_block(input logic [63:0] ct, input logic [79:0] k, input logic [63:0] exp_pt,
                           input string tag, input bit hold_ready, input int stall, input bit noise);
    int n;
    int lat;
    lat = exp_latency(k);
    @(negedge clk);
    check({tag, " in_ready_idle"}, in_ready, 1);
    ciphertext = ct;
    key        = k;
    in_valid   = 1'b1;
    out_ready  = hold_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (noise) begin
      ciphertext = ~ct;
      key        = ~k;
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      if (n == 10) begin
        check({tag, " busy_mid"}, busy, 1);
        check({tag, " in_ready_mid"}, in_ready, 0);
      end
      if (noise) in_valid = (n >= 3 && n < 40);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, n, lat);
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " plaintext"}, plaintext, exp_pt);
    cache_v = 1'b1;
    last_k  = k;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, " stall_valid"}, out_valid, 1);
      check({tag, " stall_pt"}, plaintext, exp_pt);
      check({tag, " stall_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid_drop"}, out_valid, 0);
    check({tag, " in_ready_back"}, in_ready, 1);
    check({tag, " busy_drop"}, busy, 0);
    check({tag, " pt_hold"}, plaintext, exp_pt);
  endtask

  initial begin
    logic [79:0] k;
    logic [63:0] pt;
    bit          seen;

    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ciphertext = '0;
    key        = '0;
    cache_v    = 1'b0;
    last_k     = '0;
    k          = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst plaintext", plaintext, 0);

    // Known-answer vectors, covering early out_ready, a DONE stall and ignored in_valid.
    run_block(64'h5579C1387B228445, 80'h0, 64'h0, "kat0", 1'b0, 0, 1'b0);
    run_block(64'hE72C46C0F5945049, {80{1'b1}}, 64'h0, "kat1", 1'b1, 0, 1'b0);
    run_block(64'hA112FFC72F68417B, 80'h0, {64{1'b1}}, "kat2", 1'b0, 10, 1'b0);
    run_block(64'h3333DCD3213210D2, {80{1'b1}}, {64{1'b1}}, "kat3", 1'b0, 0, 1'b1);

    // Random round trips; every third block reuses the previous key.
    for (int i = 0; i < 6; i++) begin
      if (i % 3 != 2) k = {16'($urandom), $urandom, $urandom};
      pt = {$urandom, $urandom};
      run_block(ref_encrypt(pt, k), k, pt, $sformatf("rand%0d", i), 1'b0, 0, 1'b0);
    end

    // Reset during DEC: engine drops the block and never raises out_valid.
    k  = {16'($urandom), $urandom, $urandom};
    pt = {$urandom, $urandom};
    @(negedge clk);
    ciphertext = ref_encrypt(pt, k);
    key        = k;
    in_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (52) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    cache_v = 1'b0;
    check("midrst in_ready", in_ready, 1);
    check("midrst busy", busy, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst plaintext", plaintext, 0);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("midrst no_out_valid", seen, 0);
    run_block(ref_encrypt(pt, k), k, pt, "after_rst", 1'b0, 0, 1'b0);

    // Same key twice (cache hit when enabled), then a fresh key.
    k  = {16'($urandom), $urandom, $urandom};
    pt = {$urandom, $urandom};
    run_block(ref_encrypt(pt, k), k, pt, "cache_a", 1'b0, 0, 1'b0);
    pt = {$urandom, $urandom};
    run_block(ref_encrypt(pt, k), k, pt, "cache_b", 1'b0, 0, 1'b0);
    k  = {16'($urandom), $urandom, $urandom};
    pt = {$urandom, $urandom};
    run_block(ref_encrypt(pt, k), k, pt, "cache_c", 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
